multicycle_ctrl: RTL and testbench

- Control FSM that sequences the MIPS datapath (PC, RegFile, ALU, RAM_TOP bus) over multiple cycles per instruction instead of one.
- Replaces the combinational Control for the multi-cycle CPU variant, and adds a memory/peripheral wait handshake with timeout.
- Adds precise interrupt and undefined-instruction entry into supervisor vectors.

---
 rtl/multicycle_ctrl_if.sv | 32 +++
 rtl/multicycle_ctrl.sv | 122 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/bus status into the multi-cycle control FSM and datapath controls out of it
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       irq;
  logic       supervise;
  logic       mem_ack;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [2:0] pc_src;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_sel;
  logic       alu_src2_imm;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] exc_cause;
  logic [2:0] state;
  logic       instr_done;
  modport master (
    input  opcode, funct, irq, supervise, mem_ack,
    output ir_write, pc_write, pc_write_cond, pc_src, reg_write, reg_dst, mem_to_reg,
           alu_sel, alu_src2_imm, mem_read, mem_write, exc_cause, state, instr_done
  );
  modport slave (
    output opcode, funct, irq, supervise, mem_ack,
    input  ir_write, pc_write, pc_write_cond, pc_src, reg_write, reg_dst, mem_to_reg,
           alu_sel, alu_src2_imm, mem_read, mem_write, exc_cause, state, instr_done
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM with bus-wait timeout, irq and undefined-instruction traps
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [2:0] C_R = 3'd0, C_IA = 3'd1, C_LW = 3'd2, C_SW = 3'd3,
                         C_BR = 3'd4, C_J = 3'd5, C_JAL = 3'd6, C_UND = 3'd7;
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, EXC = 3'd5} state_t;
  state_t        state_q, state_d;
  logic [2:0]    cls_q, cls_d, dec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic          timeout, jreg;
  assign dec = bus.opcode == 6'h00 ? C_R :
               bus.opcode[5:3] == 3'b001 ? C_IA :
               bus.opcode == 6'h23 ? C_LW :
               bus.opcode == 6'h2b ? C_SW :
               (bus.opcode == 6'h01 || bus.opcode[5:2] == 4'b0001) ? C_BR :
               bus.opcode == 6'h02 ? C_J :
               bus.opcode == 6'h03 ? C_JAL : C_UND;
  assign jreg      = dec == C_R && bus.funct[5:1] == 5'b00100;
  assign timeout   = MEM_TIMEOUT != 0 && cnt_q == CW'(MEM_TIMEOUT);
  assign bus.state     = state_q;
  assign bus.exc_cause = cause_q;
  always_comb begin
    state_d           = FETCH;
    cls_d             = cls_q;
    cnt_d             = '0;
    cause_d           = cause_q;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = 3'd0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 2'd0;
    bus.mem_to_reg    = 2'd0;
    bus.alu_sel       = 2'd0;
    bus.alu_src2_imm  = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.instr_done    = 1'b0;
    // Reset forces every enable low regardless of the state being abandoned
    if (!reset) begin
      case (state_q)
        FETCH: begin
          if (bus.irq && !bus.supervise) begin
            cause_d = 2'd1;
            state_d = EXC;
          end else begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = DECODE;
          end
        end
        DECODE: begin
          cls_d = dec;
          if (dec == C_J || dec == C_JAL || jreg) begin
            bus.pc_write   = 1'b1;
            bus.pc_src     = jreg ? 3'd3 : 3'd2;
            bus.reg_write  = dec == C_JAL || (jreg && bus.funct[0]);
            bus.reg_dst    = dec == C_JAL ? 2'd2 : 2'd0;
            bus.mem_to_reg = bus.reg_write ? 2'd2 : 2'd0;
            bus.instr_done = 1'b1;
          end else if (dec == C_UND) begin
            cause_d = 2'd2;
            state_d = EXC;
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          bus.alu_sel       = cls_q == C_BR ? 2'd1 : (cls_q == C_R || cls_q == C_IA) ? 2'd2 : 2'd0;
          bus.alu_src2_imm  = cls_q == C_IA || cls_q == C_LW || cls_q == C_SW;
          bus.pc_write_cond = cls_q == C_BR;
          bus.pc_src        = cls_q == C_BR ? 3'd1 : 3'd0;
          bus.instr_done    = cls_q == C_BR;
          state_d           = (cls_q == C_R || cls_q == C_IA) ? WB :
                              (cls_q == C_LW || cls_q == C_SW) ? MEM : FETCH;
        end
        MEM: begin
          bus.mem_read   = cls_q == C_LW && (bus.mem_ack || !timeout);
          bus.mem_write  = cls_q == C_SW && (bus.mem_ack || !timeout);
          bus.instr_done = bus.mem_ack && cls_q == C_SW;
          cnt_d          = (bus.mem_ack || timeout) ? '0 : cnt_q + CW'(1);
          cause_d        = (!bus.mem_ack && timeout) ? 2'd3 : cause_q;
          state_d        = bus.mem_ack ? (cls_q == C_LW ? WB : FETCH) : timeout ? EXC : MEM;
        end
        WB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = cls_q == C_R ? 2'd0 : 2'd1;
          bus.mem_to_reg = cls_q == C_LW ? 2'd1 : 2'd0;
          bus.instr_done = 1'b1;
        end
        EXC: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 2'd3;
          bus.mem_to_reg = 2'd2;
          bus.pc_write   = 1'b1;
          bus.pc_src     = cause_q == 2'd1 ? 3'd4 : 3'd5;
        end
        default: state_d = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cls_q   <= C_R;
      cnt_q   <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven per-cycle vectors plus hand sequences for MEM waits, timeout and reset
module tb_multicycle_ctrl;
  typedef struct packed {
    logic [2:0] st;
    logic       ir, pw, pwc;
    logic [2:0] src;
    logic       rw;
    logic [1:0] rd, m2r, alu;
    logic       imm, mr, mw;
    logic [1:0] cause;
    logic       done;
  } out_t;
  typedef struct {
    logic [5:0] op, fn;
    logic       irq, sup, ack;
    out_t       e;
  } vec_t;
  localparam out_t O_F  = '{st:3'd0, ir:1'b1, pw:1'b1, default:'0};
  localparam out_t O_D  = '{st:3'd1, default:'0};
  localparam out_t O_ER = '{st:3'd2, alu:2'd2, default:'0};
  localparam out_t O_EM = '{st:3'd2, imm:1'b1, default:'0};
  localparam out_t O_WR = '{st:3'd4, rw:1'b1, done:1'b1, default:'0};
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  multicycle_ctrl_if bus();
  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  function automatic out_t cur();
    return {bus.state, bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.reg_write,
            bus.reg_dst, bus.mem_to_reg, bus.alu_sel, bus.alu_src2_imm, bus.mem_read, bus.mem_write,
            bus.exc_cause, bus.instr_done};
  endfunction
  task automatic chk(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic chk_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic irq, input logic sup,
                     input logic ack, input logic [1:0] c, input out_t e);
    vec_t v;
    v.op = op; v.fn = fn; v.irq = irq; v.sup = sup; v.ack = ack; v.e = e; v.e.cause = c;
    tbl.push_back(v);
  endtask
  task automatic add_rtype(input logic [5:0] fn, input logic irq, input logic sup, input logic [1:0] c);
    add(6'h00, fn, irq, sup, 1'b0, c, O_F);
    add(6'h00, fn, irq, sup, 1'b0, c, O_D);
    add(6'h00, fn, irq, sup, 1'b0, c, O_ER);
    add(6'h00, fn, irq, sup, 1'b0, c, O_WR);
  endtask
  task automatic run_instr(input logic [5:0] op, input int ack_at, output int cyc, output int mr_n,
                           output int mw_n, output int done_n, output out_t wb, output out_t exc);
    int memc;
    out_t s;
    memc = 0; cyc = 0; mr_n = 0; mw_n = 0; done_n = 0; wb = '0; exc = '0;
    bus.opcode = op; bus.funct = 6'h00; bus.irq = 1'b0; bus.supervise = 1'b0;
    do begin
      bus.mem_ack = bus.state == 3'd3 && memc + 1 == ack_at;
      if (bus.state == 3'd3) memc++;
      @(negedge clk);
      s = cur();
      cyc++;
      mr_n += int'(s.mr);
      mw_n += int'(s.mw);
      done_n += int'(s.done);
      if (s.st == 3'd4) wb = s;
      if (s.st == 3'd5) exc = s;
      @(posedge clk); #1;
    end while (bus.state != 3'd0 && cyc < 40);
    bus.mem_ack = 1'b0;
  endtask
  initial begin
    int cyc, mr_n, mw_n, done_n;
    out_t wb, exc;
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.irq = 1'b0; bus.supervise = 1'b0; bus.mem_ack = 1'b0;
    add_rtype(6'h20, 1'b0, 1'b0, 2'd0);
    add(6'h02, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, O_F);
    add(6'h02, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, '{st:3'd1, pw:1'b1, src:3'd2, done:1'b1, default:'0});
    add(6'h03, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, O_F);
    add(6'h03, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0,
        '{st:3'd1, pw:1'b1, src:3'd2, rw:1'b1, rd:2'd2, m2r:2'd2, done:1'b1, default:'0});
    add(6'h00, 6'h08, 1'b0, 1'b0, 1'b0, 2'd0, O_F);
    add(6'h00, 6'h08, 1'b0, 1'b0, 1'b0, 2'd0, '{st:3'd1, pw:1'b1, src:3'd3, done:1'b1, default:'0});
    add(6'h00, 6'h09, 1'b0, 1'b0, 1'b0, 2'd0, O_F);
    add(6'h00, 6'h09, 1'b0, 1'b0, 1'b0, 2'd0,
        '{st:3'd1, pw:1'b1, src:3'd3, rw:1'b1, m2r:2'd2, done:1'b1, default:'0});
    add(6'h04, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, O_F);
    add(6'h04, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, O_D);
    add(6'h04, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0,
        '{st:3'd2, alu:2'd1, pwc:1'b1, src:3'd1, done:1'b1, default:'0});
    add(6'h08, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, O_F);
    add(6'h08, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, O_D);
    add(6'h08, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, '{st:3'd2, alu:2'd2, imm:1'b1, default:'0});
    add(6'h08, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, '{st:3'd4, rw:1'b1, rd:2'd1, done:1'b1, default:'0});
    add(6'h2b, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, O_F);
    add(6'h2b, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, O_D);
    add(6'h2b, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, O_EM);
    add(6'h2b, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, '{st:3'd3, mw:1'b1, default:'0});
    add(6'h2b, 6'h00, 1'b0, 1'b0, 1'b1, 2'd0, '{st:3'd3, mw:1'b1, done:1'b1, default:'0});
    add(6'h23, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, O_F);
    add(6'h23, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, O_D);
    add(6'h23, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, O_EM);
    add(6'h23, 6'h00, 1'b0, 1'b0, 1'b1, 2'd0, '{st:3'd3, mr:1'b1, default:'0});
    add(6'h23, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0,
        '{st:3'd4, rw:1'b1, rd:2'd1, m2r:2'd1, done:1'b1, default:'0});
    add_rtype(6'h20, 1'b1, 1'b1, 2'd0);
    add(6'h00, 6'h20, 1'b1, 1'b0, 1'b0, 2'd0, '{st:3'd0, default:'0});
    add(6'h00, 6'h20, 1'b1, 1'b0, 1'b0, 2'd1,
        '{st:3'd5, rw:1'b1, rd:2'd3, m2r:2'd2, pw:1'b1, src:3'd4, default:'0});
    add(6'h3f, 6'h00, 1'b1, 1'b1, 1'b0, 2'd1, O_F);
    add(6'h3f, 6'h00, 1'b1, 1'b1, 1'b0, 2'd1, O_D);
    add(6'h3f, 6'h00, 1'b1, 1'b1, 1'b0, 2'd2,
        '{st:3'd5, rw:1'b1, rd:2'd3, m2r:2'd2, pw:1'b1, src:3'd5, default:'0});
    add_rtype(6'h20, 1'b0, 1'b1, 2'd2);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", cur(), '{default:'0});
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      bus.opcode = tbl[i].op; bus.funct = tbl[i].fn; bus.irq = tbl[i].irq;
      bus.supervise = tbl[i].sup; bus.mem_ack = tbl[i].ack;
      @(negedge clk);
      chk($sformatf("vec%0d", i), cur(), tbl[i].e);
      @(posedge clk); #1;
    end
    run_instr(6'h23, 3, cyc, mr_n, mw_n, done_n, wb, exc);
    chk_i("lw_cycles", cyc, 7);
    chk_i("lw_mem_read_cycles", mr_n, 3);
    chk_i("lw_done_pulses", done_n, 1);
    chk("lw_wb", wb, '{st:3'd4, rw:1'b1, rd:2'd1, m2r:2'd1, cause:2'd2, done:1'b1, default:'0});
    run_instr(6'h2b, 16, cyc, mr_n, mw_n, done_n, wb, exc);
    chk_i("sw_ack_at_limit_cycles", cyc, 19);
    chk_i("sw_ack_at_limit_mem_write", mw_n, 16);
    chk_i("sw_ack_at_limit_done", done_n, 1);
    chk_i("sw_ack_at_limit_cause", int'(bus.exc_cause), 2);
    run_instr(6'h2b, 0, cyc, mr_n, mw_n, done_n, wb, exc);
    chk_i("sw_timeout_cycles", cyc, 20);
    chk_i("sw_timeout_mem_write", mw_n, 15);
    chk_i("sw_timeout_done", done_n, 0);
    chk("sw_timeout_exc", exc, '{st:3'd5, rw:1'b1, rd:2'd3, m2r:2'd2, pw:1'b1, src:3'd5, cause:2'd3, default:'0});
    bus.opcode = 6'h23; bus.funct = 6'h00; bus.mem_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_i("mid_mem_state", int'(bus.state), 3);
    reset = 1'b1;
    @(negedge clk);
    chk_i("reset_cycle_mem_read", int'(bus.mem_read), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("after_mid_mem_reset", cur(), O_F);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
